// File: rtl/connect_four_vga_pkg.sv
// Shared VGA timing, board geometry and colour constants for the Connect Four display.
// Also holds the helper that squares a signed disc offset.
package connect_four_vga_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb_t;

    localparam int NUM_CELLS = 42;

    localparam coord_t H_VISIBLE    = 10'd640;
    localparam coord_t H_SYNC_START = 10'd656;
    localparam coord_t H_SYNC_END   = 10'd752;
    localparam coord_t H_TOTAL      = 10'd800;
    localparam coord_t H_LAST       = H_TOTAL - 10'd1;

    localparam coord_t V_VISIBLE    = 10'd480;
    localparam coord_t V_SYNC_START = 10'd490;
    localparam coord_t V_SYNC_END   = 10'd492;
    localparam coord_t V_TOTAL      = 10'd525;
    localparam coord_t V_LAST       = V_TOTAL - 10'd1;

    localparam coord_t      CELL_SIZE  = 10'd64;
    localparam coord_t      BOARD_X0   = 10'd96;
    localparam coord_t      BOARD_Y0   = 10'd48;
    localparam coord_t      BOARD_X1   = BOARD_X0 + 10'd7 * CELL_SIZE;
    localparam coord_t      BOARD_Y1   = BOARD_Y0 + 10'd6 * CELL_SIZE;
    localparam logic [5:0]  BOARD_COLS = 6'd7;
    localparam logic [11:0] RADIUS_SQ  = 12'd784;

    localparam rgb_t BLACK  = 3'b000;
    localparam rgb_t BLUE   = 3'b001;
    localparam rgb_t RED    = 3'b100;
    localparam rgb_t YELLOW = 3'b110;

    // Offsets span -32..31, so the magnitude fits 6 bits and the square fits 12.
    function automatic logic [11:0] square7(input logic signed [6:0] v);
        logic [5:0] mag;
        mag = v[6] ? 6'(-v) : v[5:0];
        return 12'(mag) * 12'(mag);
    endfunction

endpackage

// File: rtl/connect_four_vga_sync_gen.sv
// 25 MHz pixel enable, 800x525 raster counters, sync/visible flags and the
// once-per-frame strobe that captures the board state at the start of vertical blank.
module vga_sync_gen
    import connect_four_vga_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    output logic   pix_en,
    output coord_t hc,
    output coord_t vc,
    output logic   h_sync,
    output logic   v_sync,
    output logic   visible,
    output logic   frame_latch
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en <= 1'b0;
            hc     <= '0;
            vc     <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    assign h_sync      = !(hc >= H_SYNC_START && hc < H_SYNC_END);
    assign v_sync      = !(vc >= V_SYNC_START && vc < V_SYNC_END);
    assign visible     = (hc < H_VISIBLE) && (vc < V_VISIBLE);
    assign frame_latch = pix_en && (hc == '0) && (vc == V_VISIBLE);

endmodule

// File: rtl/connect_four_vga.sv
// Connect Four board renderer: decodes the raster position into a cell and disc
// offset, looks up frame-stable shadow copies of the board, and registers RGB/sync.
module connect_four_vga
    import connect_four_vga_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 clk,
    input  logic [NUM_CELLS-1:0] game_data,
    input  logic [NUM_CELLS-1:0] empty,
    output logic                 vga_h_sync,
    output logic                 vga_v_sync,
    output logic                 vga_r,
    output logic                 vga_g,
    output logic                 vga_b
);

    logic                 pix_en;
    coord_t               hc;
    coord_t               vc;
    logic                 h_sync;
    logic                 v_sync;
    logic                 visible;
    logic                 frame_latch;
    logic [NUM_CELLS-1:0] shadow_data;
    logic [NUM_CELLS-1:0] shadow_empty;
    logic [8:0]           x_off;
    logic [8:0]           y_off;
    logic [5:0]           idx;
    logic signed [6:0]    dx;
    logic signed [6:0]    dy;
    logic [11:0]          dist_sq;
    logic                 in_board;
    logic                 in_disc;
    rgb_t                 pixel;
    rgb_t                 rgb;
    logic                 unused_clk;

    // The legacy clock input is kept only for pin compatibility.
    assign unused_clk = clk;

    vga_sync_gen u_sync (
        .clk         (sys_clk),
        .rst_n       (reset),
        .pix_en      (pix_en),
        .hc          (hc),
        .vc          (vc),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .visible     (visible),
        .frame_latch (frame_latch)
    );

    assign in_board = (hc >= BOARD_X0) && (hc < BOARD_X1) &&
                      (vc >= BOARD_Y0) && (vc < BOARD_Y1);
    assign x_off    = 9'(hc - BOARD_X0);
    assign y_off    = 9'(vc - BOARD_Y0);
    assign idx      = {3'b000, y_off[8:6]} * BOARD_COLS + {3'b000, x_off[8:6]};
    assign dx       = $signed({1'b0, x_off[5:0]}) - 7'sd32;
    assign dy       = $signed({1'b0, y_off[5:0]}) - 7'sd32;
    assign dist_sq  = square7(dx) + square7(dy);
    assign in_disc  = dist_sq < RADIUS_SQ;

    always_comb begin
        pixel = BLACK;
        if (visible && in_board) begin
            if (!in_disc)
                pixel = BLUE;
            else if (shadow_empty[idx])
                pixel = BLACK;
            else if (shadow_data[idx])
                pixel = RED;
            else
                pixel = YELLOW;
        end
    end

    // Board state is sampled only at the start of vertical blank so a frame never tears.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            shadow_data  <= '0;
            shadow_empty <= '1;
        end else if (frame_latch) begin
            shadow_data  <= game_data;
            shadow_empty <= empty;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rgb        <= BLACK;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else if (pix_en) begin
            rgb        <= pixel;
            vga_h_sync <= h_sync;
            vga_v_sync <= v_sync;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;

endmodule

// File: tb/tb_connect_four_vga.sv
// Directed bench for connect_four_vga: sync timing, disc colours, frame latching
// and mid-frame reset, with pixel positions tracked from the moment reset releases.
module tb_connect_four_vga;

    localparam int LINE  = 800;
    localparam int FRAME = 420000;

    logic        sys_clk = 1'b0;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [41:0] game_data = '0;
    logic [41:0] empty = '1;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [2:0]  rgb;

    connect_four_vga dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clk        (clk),
        .game_data  (game_data),
        .empty      (empty),
        .vga_h_sync (vga_h_sync),
        .vga_v_sync (vga_v_sync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #10 sys_clk = ~sys_clk;
    always #7 clk = ~clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // Pixel p (linear count from reset release) is on the outputs after sys_clk edge 2p+2.
    task automatic sample_pixel(input int frame, input int x, input int y, output logic [2:0] value);
        int target;
        target = 2 * (frame * FRAME + y * LINE + x) + 2;
        if (cyc > target) begin
            checks++;
            errors++;
            $display("[TB] FAIL schedule: at cycle %0d, required cycle %0d", cyc, target);
        end
        while (cyc < target) tick();
        value = {vga_r, vga_g, vga_b};
    endtask

    task automatic expect_pixel(input string name, input int frame, input int x, input int y,
                                input logic [2:0] expected);
        sample_pixel(frame, x, y, rgb);
        checks++;
        if (rgb !== expected) begin
            errors++;
            $display("[TB] FAIL %s (%0d,%0d): rgb=%b required %b", name, x, y, rgb, expected);
        end
    endtask

    // Release lands between clock edges; the first h-sync fall is 656 pixels plus the output register.
    task automatic release_and_find_hsync(input string name);
        reset = 1'b1;
        cyc = 0;
        while (vga_h_sync !== 1'b0 && cyc < 2000) tick();
        checks++;
        if (cyc < 1312 || cyc > 1316) begin
            errors++;
            $display("[TB] FAIL %s: h-sync fell at cycle %0d, required 1312..1316", name, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #100;
        checks++;
        if ({vga_h_sync, vga_v_sync} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_sync: syncs=%b required 11", {vga_h_sync, vga_v_sync});
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_rgb: rgb=%b required 000", {vga_r, vga_g, vga_b});
        end
        #5;
        release_and_find_hsync("first_hsync_fall");
    endtask

    task automatic test_hsync();
        int start;
        int blank_bad;
        blank_bad = 0;
        for (int line = 0; line < 2; line++) begin
            start = cyc;
            while (vga_h_sync === 1'b0 && cyc - start < 2000) begin
                if ({vga_r, vga_g, vga_b} !== 3'b000) blank_bad++;
                tick();
            end
            checks++;
            if (cyc - start != 192) begin
                errors++;
                $display("[TB] FAIL hsync_low: %0d cycles, required 192", cyc - start);
            end
            while (vga_h_sync === 1'b1 && cyc - start < 4000) tick();
            checks++;
            if (cyc - start != 1600) begin
                errors++;
                $display("[TB] FAIL hsync_period: %0d cycles, required 1600", cyc - start);
            end
        end
        checks++;
        if (blank_bad != 0) begin
            errors++;
            $display("[TB] FAIL hblank_rgb: %0d non-black samples, required 0", blank_bad);
        end
    endtask

    // New inputs arrive mid frame 0, but the shadow still shows the reset (empty) board.
    task automatic test_first_frame_empty();
        empty = '0;
        game_data = 42'h081;
        expect_pixel("f0_corner", 0, 96, 48, 3'b001);
        expect_pixel("f0_cell0", 0, 128, 80, 3'b000);
        expect_pixel("f0_cell41", 0, 512, 400, 3'b000);
    endtask

    task automatic test_vsync();
        int start;
        int blank_bad;
        blank_bad = 0;
        while (vga_v_sync === 1'b1 && cyc < 800000) tick();
        checks++;
        if (cyc != 784002) begin
            errors++;
            $display("[TB] FAIL vsync_first_fall: cycle %0d, required 784002", cyc);
        end
        start = cyc;
        while (vga_v_sync === 1'b0 && cyc - start < 5000) begin
            if ({vga_r, vga_g, vga_b} !== 3'b000) blank_bad++;
            tick();
        end
        checks++;
        if (cyc - start != 3200) begin
            errors++;
            $display("[TB] FAIL vsync_low: %0d cycles, required 3200", cyc - start);
        end
        checks++;
        if (blank_bad != 0) begin
            errors++;
            $display("[TB] FAIL vblank_rgb: %0d non-black samples, required 0", blank_bad);
        end
    endtask

    task automatic test_disc_colours();
        expect_pixel("cell_corner", 1, 96, 48, 3'b001);
        expect_pixel("outside", 1, 50, 50, 3'b000);
        expect_pixel("radius_edge", 1, 100, 80, 3'b001);
        expect_pixel("radius_inside", 1, 101, 80, 3'b100);
        expect_pixel("cell0_red", 1, 128, 80, 3'b100);
        expect_pixel("cell1_yellow", 1, 192, 80, 3'b110);
        expect_pixel("right_of_board", 1, 600, 100, 3'b000);
        expect_pixel("cell7_red", 1, 128, 144, 3'b100);
    endtask

    task automatic test_frame_latch();
        sample_pixel(1, 0, 200, rgb);
        game_data = 42'h200_0000_4000;
        expect_pixel("old_cell14", 1, 128, 208, 3'b110);
        expect_pixel("old_cell41", 1, 512, 400, 3'b110);
        while (vga_v_sync === 1'b1 && cyc < 1625000) tick();
        checks++;
        if (cyc != 1624002) begin
            errors++;
            $display("[TB] FAIL vsync_period: fall at cycle %0d, required 1624002", cyc);
        end
        expect_pixel("new_cell0", 2, 128, 80, 3'b110);
        expect_pixel("new_cell14", 2, 128, 208, 3'b100);
        expect_pixel("new_cell41", 2, 512, 400, 3'b100);
    endtask

    task automatic test_empty_board();
        empty = '1;
        expect_pixel("empty_corner", 3, 96, 48, 3'b001);
        expect_pixel("empty_cell0", 3, 128, 80, 3'b000);
        expect_pixel("empty_far_corner", 3, 159, 111, 3'b001);
        expect_pixel("empty_cell24", 3, 320, 272, 3'b000);
        expect_pixel("empty_cell27", 3, 512, 272, 3'b000);
    endtask

    task automatic test_mid_frame_reset();
        expect_pixel("pre_reset_blue", 3, 96, 300, 3'b001);
        empty = '0;
        game_data = '1;
        sample_pixel(3, 700, 300, rgb);
        checks++;
        if (vga_h_sync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset_hsync: hsync=%b required 0", vga_h_sync);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL async_clear: sync/rgb=%b required 11000",
                     {vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b});
        end
        #100;
        release_and_find_hsync("restart_hsync_fall");
        expect_pixel("restart_corner", 0, 96, 48, 3'b001);
        expect_pixel("restart_cell0", 0, 128, 80, 3'b000);
        expect_pixel("restart_cell41", 0, 512, 400, 3'b000);
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_first_frame_empty();
        test_vsync();
        test_disc_colours();
        test_frame_latch();
        test_empty_board();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
